// File: rtl/gshare_predictor_pipe.sv
// Gshare/gselect branch direction predictor with speculative global history,
// mispredict repair, a power-on table sweep and saturating statistics.
module gshare_predictor_pipe #(
  parameter int PC_W      = 32,
  parameter int PC_LSB    = 2,
  parameter int IDX_W     = 10,
  parameter int GHR_W     = 10,
  parameter int CTR_W     = 2,
  parameter int HASH_MODE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pred_valid,
  input  logic [PC_W-1:0]  pred_pc,
  output logic             pred_ready,
  output logic             resp_valid,
  output logic             resp_taken,
  output logic [IDX_W-1:0] resp_idx,
  output logic [GHR_W-1:0] resp_ghr,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic             upd_mispred,
  input  logic [GHR_W-1:0] upd_ghr,
  output logic             init_busy,
  output logic [31:0]      stat_lookups,
  output logic [31:0]      stat_mispreds
);

  localparam int DEPTH = 2 ** IDX_W;
  localparam logic [CTR_W-1:0] CTR_WEAK = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_MIN  = {CTR_W{1'b0}};

  typedef enum logic {INIT, RUN} state_t;

  state_t           state, next_state;
  logic [IDX_W-1:0] sweep_ptr;
  logic [GHR_W-1:0] ghr;
  logic [CTR_W-1:0] pht [DEPTH];
  logic [IDX_W-1:0] lookup_idx;
  logic             pred_dir;
  logic             accept;
  logic             repair;
  logic             unused_bits;

  assign unused_bits = ^{pred_pc, upd_ghr};

  generate
    if (HASH_MODE == 0) begin : g_gshare
      assign lookup_idx = pred_pc[PC_LSB +: IDX_W] ^ IDX_W'(ghr);
    end else begin : g_gselect
      assign lookup_idx = {pred_pc[PC_LSB +: (IDX_W-GHR_W)], ghr};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= INIT;
      sweep_ptr <= '0;
    end else begin
      state <= next_state;
      if (state == INIT) sweep_ptr <= sweep_ptr + IDX_W'(1);
    end
  end

  always_comb begin
    next_state = state;
    init_busy  = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        if (sweep_ptr == {IDX_W{1'b1}}) next_state = RUN;
      end
      RUN: ;
      default: next_state = INIT;
    endcase
  end

  // A repairing update owns the GHR this cycle, so lookups are stalled.
  assign pred_ready = (state == RUN) && !(upd_valid && upd_mispred);
  assign accept     = pred_valid && pred_ready;
  assign repair     = (state == RUN) && upd_valid && upd_mispred;
  assign pred_dir   = pht[lookup_idx][CTR_W-1];

  always_ff @(posedge clk) begin
    if (state == INIT) begin
      pht[sweep_ptr] <= CTR_WEAK;
    end else if (upd_valid) begin
      if (upd_taken && pht[upd_idx] != CTR_MAX)
        pht[upd_idx] <= pht[upd_idx] + CTR_W'(1);
      else if (!upd_taken && pht[upd_idx] != CTR_MIN)
        pht[upd_idx] <= pht[upd_idx] - CTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ghr           <= '0;
      resp_valid    <= 1'b0;
      resp_taken    <= 1'b0;
      resp_idx      <= '0;
      resp_ghr      <= '0;
      stat_lookups  <= '0;
      stat_mispreds <= '0;
    end else begin
      resp_valid <= accept;
      if (accept) begin
        resp_taken <= pred_dir;
        resp_idx   <= lookup_idx;
        resp_ghr   <= ghr;
      end
      if (repair)
        ghr <= {upd_ghr[GHR_W-2:0], upd_taken};
      else if (accept)
        ghr <= {ghr[GHR_W-2:0], pred_dir};
      if (accept && stat_lookups != 32'hFFFF_FFFF)
        stat_lookups <= stat_lookups + 32'd1;
      if (repair && stat_mispreds != 32'hFFFF_FFFF)
        stat_mispreds <= stat_mispreds + 32'd1;
    end
  end

endmodule

// File: tb/tb_gshare_predictor_pipe.sv
// Self-checking bench: a table-level model checked every cycle, plus directed
// vectors with literal expectations, and a gselect instance for the index hash.
module tb_gshare_predictor_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pred_valid, pred_ready, resp_valid, resp_taken;
  logic [31:0] pred_pc;
  logic [9:0]  resp_idx, resp_ghr, upd_idx, upd_ghr;
  logic        upd_valid, upd_taken, upd_mispred, init_busy;
  logic [31:0] stat_lookups, stat_mispreds;

  logic        s_pred_valid, s_pred_ready, s_resp_valid, s_resp_taken;
  logic [31:0] s_pred_pc;
  logic [9:0]  s_resp_idx, s_upd_idx;
  logic [3:0]  s_resp_ghr, s_upd_ghr;
  logic        s_upd_valid, s_upd_taken, s_upd_mispred, s_init_busy;
  logic [31:0] s_stat_lookups, s_stat_mispreds;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gshare_predictor_pipe dut (
    .clk(clk), .reset_n(reset_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_ready(pred_ready),
    .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_idx(resp_idx),
    .resp_ghr(resp_ghr), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_mispred(upd_mispred), .upd_ghr(upd_ghr),
    .init_busy(init_busy), .stat_lookups(stat_lookups), .stat_mispreds(stat_mispreds)
  );

  gshare_predictor_pipe #(.GHR_W(4), .HASH_MODE(1)) dut_sel (
    .clk(clk), .reset_n(reset_n),
    .pred_valid(s_pred_valid), .pred_pc(s_pred_pc), .pred_ready(s_pred_ready),
    .resp_valid(s_resp_valid), .resp_taken(s_resp_taken), .resp_idx(s_resp_idx),
    .resp_ghr(s_resp_ghr), .upd_valid(s_upd_valid), .upd_idx(s_upd_idx),
    .upd_taken(s_upd_taken), .upd_mispred(s_upd_mispred), .upd_ghr(s_upd_ghr),
    .init_busy(s_init_busy), .stat_lookups(s_stat_lookups), .stat_mispreds(s_stat_mispreds)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: counters as integers, history as an integer, sweep as a cycle countdown.
  int          m_pht [1024];
  int          m_ghr, m_init_left, m_ridx, m_rghr;
  bit          m_rv, m_rt;
  longint      m_look, m_mis;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 1024; i++) m_pht[i] = 2;
      m_ghr = 0; m_init_left = 1024; m_rv = 0; m_rt = 0;
      m_ridx = 0; m_rghr = 0; m_look = 0; m_mis = 0;
    end else if (m_init_left > 0) begin
      m_init_left--;
      m_rv = 0;
    end else begin
      bit acc;
      bit dir;
      int idx;
      acc = pred_valid && !(upd_valid && upd_mispred);
      m_rv = acc;
      dir = 0;
      if (acc) begin
        idx = int'((pred_pc >> 2) & 32'h3FF) ^ m_ghr;
        dir = (m_pht[idx] >= 2);
        m_rt = dir; m_ridx = idx; m_rghr = m_ghr;
        if (m_look < 64'hFFFF_FFFF) m_look++;
      end
      if (upd_valid) begin
        if (upd_taken && m_pht[upd_idx] < 3) m_pht[upd_idx]++;
        else if (!upd_taken && m_pht[upd_idx] > 0) m_pht[upd_idx]--;
      end
      if (upd_valid && upd_mispred) begin
        m_ghr = ((int'(upd_ghr) << 1) | int'(upd_taken)) & 32'h3FF;
        if (m_mis < 64'hFFFF_FFFF) m_mis++;
      end else if (acc) begin
        m_ghr = ((m_ghr << 1) | int'(dir)) & 32'h3FF;
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("resp_valid", 32'(resp_valid), 32'(m_rv));
    checkOutput("resp_taken", 32'(resp_taken), 32'(m_rt));
    checkOutput("resp_idx", 32'(resp_idx), 32'(m_ridx));
    checkOutput("resp_ghr", 32'(resp_ghr), 32'(m_rghr));
    checkOutput("init_busy", 32'(init_busy), 32'(m_init_left > 0));
    checkOutput("pred_ready", 32'(pred_ready),
                32'(m_init_left == 0 && !(upd_valid && upd_mispred)));
    checkOutput("stat_lookups", stat_lookups, 32'(m_look));
    checkOutput("stat_mispreds", stat_mispreds, 32'(m_mis));
  end

  task automatic applyStimulus(input bit pv, input logic [31:0] pc, input bit uv,
                               input logic [9:0] ui, input bit ut, input bit um,
                               input logic [9:0] ug);
    @(posedge clk); #1;
    pred_valid = pv; pred_pc = pc; upd_valid = uv; upd_idx = ui;
    upd_taken = ut; upd_mispred = um; upd_ghr = ug;
  endtask

  task automatic idle();
    applyStimulus(0, 32'h0, 0, 10'h0, 0, 0, 10'h0);
  endtask

  task automatic lookup(input logic [31:0] pc);
    applyStimulus(1, pc, 0, 10'h0, 0, 0, 10'h0);
    idle();
  endtask

  task automatic update(input logic [9:0] ui, input bit ut, input bit um, input logic [9:0] ug);
    applyStimulus(0, 32'h0, 1, ui, ut, um, ug);
    idle();
  endtask

  task automatic countInit(output int n);
    n = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (init_busy) n++;
      else break;
    end
  endtask

  int n;

  initial begin
    reset_n = 1'b0;
    pred_valid = 0; pred_pc = 0; upd_valid = 0; upd_idx = 0;
    upd_taken = 0; upd_mispred = 0; upd_ghr = 0;
    s_pred_valid = 0; s_pred_pc = 0; s_upd_valid = 0; s_upd_idx = 0;
    s_upd_taken = 0; s_upd_mispred = 0; s_upd_ghr = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_resp_valid", 32'(resp_valid), 32'h0);
    checkOutput("rst_init_busy", 32'(init_busy), 32'h1);
    checkOutput("rst_pred_ready", 32'(pred_ready), 32'h0);
    checkOutput("rst_stat_lookups", stat_lookups, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    countInit(n);
    checkOutput("init_cycles", 32'(n), 32'd1024);

    lookup(32'h100);
    checkOutput("first_valid", 32'(resp_valid), 32'h1);
    checkOutput("first_taken", 32'(resp_taken), 32'h1);
    checkOutput("first_idx", 32'(resp_idx), 32'h040);
    checkOutput("first_ghr", 32'(resp_ghr), 32'h000);
    checkOutput("first_lookups", stat_lookups, 32'd1);
    idle();
    checkOutput("pulse_end", 32'(resp_valid), 32'h0);

    // gselect instance: repair its history to 0x5, then hash pc 0x104
    @(posedge clk); #1;
    s_upd_valid = 1; s_upd_idx = 10'h0; s_upd_taken = 1; s_upd_mispred = 1; s_upd_ghr = 4'h2;
    @(posedge clk); #1;
    s_upd_valid = 0; s_upd_mispred = 0; s_pred_valid = 1; s_pred_pc = 32'h104;
    @(posedge clk); #1;
    s_pred_valid = 0;
    checkOutput("sel_valid", 32'(s_resp_valid), 32'h1);
    checkOutput("sel_idx", 32'(s_resp_idx), 32'h015);
    checkOutput("sel_ghr", 32'(s_resp_ghr), 32'h5);
    checkOutput("sel_taken", 32'(s_resp_taken), 32'h1);

    // saturation low, then high
    repeat (4) update(10'h040, 0, 0, 10'h0);
    update(10'h3FF, 0, 1, 10'h000);
    lookup(32'h100);
    checkOutput("sat_low_taken", 32'(resp_taken), 32'h0);
    checkOutput("sat_low_ghr", 32'(resp_ghr), 32'h000);
    repeat (4) update(10'h040, 1, 0, 10'h0);
    lookup(32'h100);
    checkOutput("sat_high_taken", 32'(resp_taken), 32'h1);
    checkOutput("mispreds_1", stat_mispreds, 32'd1);

    // speculation and repair
    update(10'h3FF, 0, 1, 10'h000);
    repeat (3) lookup(32'h200);
    checkOutput("spec_ghr_before_3rd", 32'(resp_ghr), 32'h003);
    checkOutput("spec_taken_3rd", 32'(resp_taken), 32'h1);
    applyStimulus(1, 32'h200, 1, 10'h3FF, 0, 1, 10'h001);
    #1;
    checkOutput("repair_ready", 32'(pred_ready), 32'h0);
    idle();
    checkOutput("repair_no_resp", 32'(resp_valid), 32'h0);
    checkOutput("mispreds_3", stat_mispreds, 32'd3);

    // collision: lookup and not-taken update hit idx 0x082 in the same cycle
    applyStimulus(1, 32'h200, 1, 10'h082, 0, 0, 10'h0);
    idle();
    checkOutput("coll_ghr", 32'(resp_ghr), 32'h002);
    checkOutput("coll_idx", 32'(resp_idx), 32'h082);
    checkOutput("coll_taken", 32'(resp_taken), 32'h1);
    update(10'h3FF, 0, 1, 10'h001);
    lookup(32'h200);
    checkOutput("coll_after_idx", 32'(resp_idx), 32'h082);
    checkOutput("coll_after_taken", 32'(resp_taken), 32'h0);
    checkOutput("lookups_8", stat_lookups, 32'd8);

    // reset in the middle of the sweep restarts it from entry 0
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
    repeat (500) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("midsweep_busy", 32'(init_busy), 32'h1);
    @(posedge clk); #1 reset_n = 1'b1;
    countInit(n);
    checkOutput("resweep_cycles", 32'(n), 32'd1024);
    checkOutput("resweep_lookups", stat_lookups, 32'h0);
    checkOutput("resweep_mispreds", stat_mispreds, 32'h0);
    lookup(32'h208);
    checkOutput("resweep_idx", 32'(resp_idx), 32'h082);
    checkOutput("resweep_ghr", 32'(resp_ghr), 32'h000);
    checkOutput("resweep_taken", 32'(resp_taken), 32'h1);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
